// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the four-requester dual-port RAM arbiter.
// Holds the port enum, the response tag layout and the round-robin pointer step.
package dpram_arb_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   typedef struct packed {
      logic       valid;
      logic       is_read;
      logic [1:0] idx;
   } tag_t;

   localparam tag_t TAG_IDLE = '{valid: 1'b0, is_read: 1'b0, idx: 2'd0};

   function automatic logic [1:0] next_ptr(input logic [1:0] idx);
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/dpram_arbiter_rr_pick2.sv
// Round-robin selector: picks the first two valid requesters starting at ptr.
// Purely combinational so it can be exercised on its own.
module rr_pick2 (
   input  logic [3:0] valid,
   input  logic [1:0] ptr,
   output logic [1:0] first,
   output logic       first_found,
   output logic [1:0] second,
   output logic       second_found
);

   logic [1:0] idx;

   // scan ptr, ptr+1, ... modulo 4 and keep the first two hits
   always_comb begin
      first        = 2'd0;
      first_found  = 1'b0;
      second       = 2'd0;
      second_found = 1'b0;
      idx          = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (valid[idx] && !first_found) begin
            first       = idx;
            first_found = 1'b1;
         end else if (valid[idx] && !second_found) begin
            second       = idx;
            second_found = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/dpram_arbiter.sv
// Grants up to two requesters per cycle onto RAM ports A/B, blocks same-address
// hazards between the ports and returns read data one cycle after the grant.
module dpram_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int NREQ   = dpram_arb_pkg::NREQ
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [NREQ*DATA_W-1:0]   rsp_rdata,
   output logic                     ram_we_a,
   output logic                     ram_we_b,
   output logic [ADDR_W-1:0]        ram_addr_a,
   output logic [ADDR_W-1:0]        ram_addr_b,
   output logic [DATA_W-1:0]        ram_din_a,
   output logic [DATA_W-1:0]        ram_din_b,
   input  logic [DATA_W-1:0]        ram_dout_a,
   input  logic [DATA_W-1:0]        ram_dout_b
);
   import dpram_arb_pkg::*;

   logic [1:0] ptr;
   logic [1:0] first;
   logic [1:0] second;
   logic       first_found;
   logic       second_found;
   logic       hazard;
   logic       grant_a;
   logic       grant_b;
   tag_t       tag [2];

   rr_pick2 u_pick (
      .valid        (req_valid),
      .ptr          (ptr),
      .first        (first),
      .first_found  (first_found),
      .second       (second),
      .second_found (second_found)
   );

   // Port B may not touch A's address in the same cycle if either side writes.
   assign hazard  = (req_addr[first*ADDR_W +: ADDR_W] == req_addr[second*ADDR_W +: ADDR_W])
                    && (req_we[first] || req_we[second]);
   assign grant_a = rst_n & first_found;
   assign grant_b = rst_n & second_found & ~hazard;

   // drive grants and RAM port controls from the selected requesters
   always_comb begin
      req_ready  = '0;
      ram_we_a   = 1'b0;
      ram_addr_a = '0;
      ram_din_a  = '0;
      ram_we_b   = 1'b0;
      ram_addr_b = '0;
      ram_din_b  = '0;
      if (grant_a) begin
         req_ready[first] = 1'b1;
         ram_we_a         = req_we[first];
         ram_addr_a       = req_addr[first*ADDR_W +: ADDR_W];
         ram_din_a        = req_wdata[first*DATA_W +: DATA_W];
      end else begin
         ram_we_a = 1'b0;
      end
      if (grant_b) begin
         req_ready[second] = 1'b1;
         ram_we_b          = req_we[second];
         ram_addr_b        = req_addr[second*ADDR_W +: ADDR_W];
         ram_din_b         = req_wdata[second*DATA_W +: DATA_W];
      end else begin
         ram_we_b = 1'b0;
      end
   end

   // round-robin pointer and per-port response tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= 2'd0;
         tag[PORT_A] <= TAG_IDLE;
         tag[PORT_B] <= TAG_IDLE;
      end else begin
         if (grant_b) begin
            ptr <= next_ptr(second);
         end else if (grant_a) begin
            ptr <= next_ptr(first);
         end else begin
            ptr <= ptr;
         end
         tag[PORT_A] <= '{valid: grant_a, is_read: ~req_we[first],  idx: first};
         tag[PORT_B] <= '{valid: grant_b, is_read: ~req_we[second], idx: second};
      end
   end

   // route registered RAM read data back to the owning requester
   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      if (tag[PORT_A].valid && tag[PORT_A].is_read) begin
         rsp_valid[tag[PORT_A].idx]                   = 1'b1;
         rsp_rdata[tag[PORT_A].idx*DATA_W +: DATA_W]  = ram_dout_a;
      end else begin
      end
      if (tag[PORT_B].valid && tag[PORT_B].is_read) begin
         rsp_valid[tag[PORT_B].idx]                   = 1'b1;
         rsp_rdata[tag[PORT_B].idx*DATA_W +: DATA_W]  = ram_dout_b;
      end else begin
      end
   end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural dual-port RAM attached.
module tb_dpram_arbiter;

   localparam int DW = 8;
   localparam int AW = 10;
   localparam int NR = 4;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_we;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     rsp_valid;
   logic [NR*DW-1:0]  rsp_rdata;
   logic              ram_we_a, ram_we_b;
   logic [AW-1:0]     ram_addr_a, ram_addr_b;
   logic [DW-1:0]     ram_din_a, ram_din_b;
   logic [DW-1:0]     ram_dout_a, ram_dout_b;

   logic [DW-1:0]     mem [1024];
   int                n_tests;
   int                n_fail;

   dpram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREQ(NR)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .ram_we_a   (ram_we_a),
      .ram_we_b   (ram_we_b),
      .ram_addr_a (ram_addr_a),
      .ram_addr_b (ram_addr_b),
      .ram_din_a  (ram_din_a),
      .ram_din_b  (ram_din_b),
      .ram_dout_a (ram_dout_a),
      .ram_dout_b (ram_dout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory preload: mem[a] = a[7:0] ^ 0xA5
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
   end

   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
      ram_dout_a <= mem[ram_addr_a];
      ram_dout_b <= mem[ram_addr_b];
   end

   task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]         = 1'b1;
      req_we[i]            = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic drop(input int i);
      req_valid[i] = 1'b0;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;

      // reset state with requests pending
      #2;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 10'h100, 8'h11);
      #1;
      check_eq("rst_ready", 40'(req_ready), 40'h0);
      check_eq("rst_we_a", 40'(ram_we_a), 40'h0);
      check_eq("rst_we_b", 40'(ram_we_b), 40'h0);
      check_eq("rst_addr_a", 40'(ram_addr_a), 40'h0);
      check_eq("rst_rsp", 40'(rsp_valid), 40'h0);
      req_valid = '0;
      req_we    = '0;

      // single writer then read-back
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 1'b1, 10'h010, 8'h5A);
      #1;
      check_eq("wr_ready", 40'(req_ready), 40'h1);
      check_eq("wr_we_a", 40'(ram_we_a), 40'h1);
      check_eq("wr_addr_a", 40'(ram_addr_a), 40'h010);
      check_eq("wr_din_a", 40'(ram_din_a), 40'h5A);
      check_eq("wr_we_b", 40'(ram_we_b), 40'h0);
      @(posedge clk); #1;
      check_eq("wr_no_rsp", 40'(rsp_valid), 40'h0);
      @(negedge clk);
      set_req(0, 1'b0, 10'h010, 8'h00);
      #1;
      check_eq("rd_ready", 40'(req_ready), 40'h1);
      check_eq("rd_we_a", 40'(ram_we_a), 40'h0);
      @(posedge clk); #1;
      check_eq("rd_rsp", 40'(rsp_valid), 40'h1);
      check_eq("rd_data", 40'(rsp_rdata), 40'h5A);
      @(negedge clk);
      drop(0);
      @(posedge clk); #1;
      check_eq("rd_rsp_once", 40'(rsp_valid), 40'h0);

      // burst at ptr=1, then reset with requests outstanding
      @(negedge clk);
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10'(10'h100 + i), 8'h00);
      #1;
      check_eq("b1_ready", 40'(req_ready), 40'h6);
      check_eq("b1_addr_a", 40'(ram_addr_a), 40'h101);
      check_eq("b1_addr_b", 40'(ram_addr_b), 40'h102);
      @(posedge clk); #1;
      check_eq("b1_rsp", 40'(rsp_valid), 40'h6);
      check_eq("b1_data", 40'(rsp_rdata), 40'h00A7A400);
      @(negedge clk);
      drop(1);
      drop(2);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_ready", 40'(req_ready), 40'h0);
      check_eq("mid_rst_we", 40'({ram_we_a, ram_we_b}), 40'h0);
      check_eq("mid_rst_rsp", 40'(rsp_valid), 40'h0);
      @(posedge clk); #1;
      check_eq("in_rst_rsp", 40'(rsp_valid), 40'h0);

      // after release: four reads, ptr restarts at 0
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10'(10'h100 + i), 8'h00);
      #1;
      check_eq("rel_rsp", 40'(rsp_valid), 40'h0);
      check_eq("all_c1_ready", 40'(req_ready), 40'h3);
      @(posedge clk); #1;
      check_eq("all_c1_rsp", 40'(rsp_valid), 40'h3);
      check_eq("all_c1_data", 40'(rsp_rdata), 40'h0000A4A5);
      @(negedge clk);
      drop(0);
      drop(1);
      #1;
      check_eq("all_c2_ready", 40'(req_ready), 40'hC);
      check_eq("all_c2_addr_a", 40'(ram_addr_a), 40'h102);
      check_eq("all_c2_addr_b", 40'(ram_addr_b), 40'h103);
      @(posedge clk); #1;
      check_eq("all_c2_rsp", 40'(rsp_valid), 40'hC);
      check_eq("all_c2_data", 40'(rsp_rdata), 40'hA6A70000);

      // same-address reads on both ports
      @(negedge clk);
      drop(2);
      drop(3);
      set_req(0, 1'b0, 10'h3FF, 8'h00);
      set_req(3, 1'b0, 10'h3FF, 8'h00);
      #1;
      check_eq("same_ready", 40'(req_ready), 40'h9);
      check_eq("same_addr_b", 40'(ram_addr_b), 40'h3FF);
      @(posedge clk); #1;
      check_eq("same_rsp", 40'(rsp_valid), 40'h9);
      check_eq("same_data", 40'(rsp_rdata), 40'h5A00005A);
      @(negedge clk);
      drop(3);
      set_req(0, 1'b1, 10'h020, 8'h77);
      #1;
      check_eq("w20_ready", 40'(req_ready), 40'h1);
      @(posedge clk);

      // hazard: write and read of 0x200 at ptr=1
      @(negedge clk);
      drop(0);
      set_req(1, 1'b1, 10'h200, 8'h33);
      set_req(2, 1'b0, 10'h200, 8'h00);
      #1;
      check_eq("hz_ready", 40'(req_ready), 40'h2);
      check_eq("hz_we_a", 40'(ram_we_a), 40'h1);
      check_eq("hz_we_b", 40'(ram_we_b), 40'h0);
      check_eq("hz_addr_b", 40'(ram_addr_b), 40'h0);
      @(posedge clk); #1;
      check_eq("hz_rsp", 40'(rsp_valid), 40'h0);
      @(negedge clk);
      drop(1);
      #1;
      check_eq("hz2_ready", 40'(req_ready), 40'h4);
      check_eq("hz2_addr_a", 40'(ram_addr_a), 40'h200);
      @(posedge clk); #1;
      check_eq("hz2_rsp", 40'(rsp_valid), 40'h4);
      check_eq("hz2_data", 40'(rsp_rdata), 40'h00330000);

      // fairness with ptr wrapping 3 -> 0 -> 1
      @(negedge clk);
      drop(2);
      set_req(0, 1'b0, 10'h020, 8'h00);
      #1;
      check_eq("fair1_ready", 40'(req_ready), 40'h1);
      @(posedge clk); #1;
      check_eq("fair1_data", 40'(rsp_rdata), 40'h00000077);
      @(negedge clk);
      set_req(2, 1'b0, 10'h010, 8'h00);
      #1;
      check_eq("fair2_ready", 40'(req_ready), 40'h5);
      check_eq("fair2_addr_a", 40'(ram_addr_a), 40'h010);
      check_eq("fair2_addr_b", 40'(ram_addr_b), 40'h020);
      @(posedge clk); #1;
      check_eq("fair2_rsp", 40'(rsp_valid), 40'h5);
      check_eq("fair2_data", 40'(rsp_rdata), 40'h005A0077);
      @(negedge clk);
      drop(2);
      #1;
      check_eq("fair3_ready", 40'(req_ready), 40'h1);
      @(negedge clk);
      drop(0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("idle_rsp", 40'(rsp_valid), 40'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
